// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: state codes, line level,
// WAIT timeout and the clocks-per-bit derivation.
package fifo_uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_PARITY = 3'd4;
   localparam logic [2:0] ST_STOP   = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_WAIT   = ST_WAIT,
      S_START  = ST_START,
      S_DATA   = ST_DATA,
      S_PARITY = ST_PARITY,
      S_STOP   = ST_STOP
   } state_t;

   localparam logic TX_IDLE = 1'b1;
   localparam int   WAIT_TO = 2;

   function automatic int calc_cpb(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: counts 0..CPB-1, ticks on the last count, restartable.
module baud_tick_gen
   import fifo_uart_pkg::*;
#(
   parameter int CPB = 5208,
   parameter int CW  = $clog2(CPB)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_restart,
   output logic          o_tick,
   output logic [CW-1:0] o_cnt
);

   localparam logic [CW-1:0] LAST = CW'(CPB - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_restart || (r_cnt == LAST))
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_tick = (r_cnt == LAST);
   assign o_cnt  = r_cnt;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO reader + 8N1 UART transmitter. Define FIFO_UART_TX_PARITY_EN to insert
// an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_empty,
   input  logic       i_data_ready,
   input  logic [7:0] i_din,
   output logic       o_rd,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_byte_done,
   output logic       o_err
);

   localparam int CPB = calc_cpb(CLK_FREQ, BAUD);
   localparam int CW  = $clog2(CPB);
   localparam logic [CW-1:0] DONE_CNT = CW'(CPB - 2);
   localparam logic [1:0]    WAIT_LAST = 2'(WAIT_TO - 1);

   state_t        r_state, w_state_n;
   logic [7:0]    r_shift, w_shift_n;
   logic [2:0]    r_bitcnt, w_bitcnt_n;
   logic [1:0]    r_wcnt, w_wcnt_n;
   logic          r_rd, r_tx, r_busy, r_done, r_err;
   logic          w_rd_n, w_tx_n, w_busy_n, w_err_n;
   logic          w_tick, w_restart;
   logic [CW-1:0] w_cnt;
`ifdef FIFO_UART_TX_PARITY_EN
   logic          r_par, w_par_n;
`endif

   // Timer restarts on every state change so each state begins at count 0.
   baud_tick_gen #(.CPB(CPB), .CW(CW)) u_baud (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_restart (w_restart),
      .o_tick    (w_tick),
      .o_cnt     (w_cnt)
   );

   assign w_restart = (w_state_n != r_state);

   always_comb begin
      w_state_n  = r_state;
      w_shift_n  = r_shift;
      w_bitcnt_n = r_bitcnt;
      w_wcnt_n   = r_wcnt;
      w_err_n    = r_err;
`ifdef FIFO_UART_TX_PARITY_EN
      w_par_n    = r_par;
`endif
      case (r_state)
         S_IDLE: begin
            if (r_rd) begin
               w_state_n = S_WAIT;
               w_wcnt_n  = '0;
            end
         end
         S_WAIT: begin
            if (i_data_ready) begin
               w_shift_n = i_din;
`ifdef FIFO_UART_TX_PARITY_EN
               w_par_n   = ^i_din;
`endif
               w_state_n = S_START;
            end else if (r_wcnt == WAIT_LAST) begin
               w_err_n   = 1'b1;
               w_state_n = S_IDLE;
            end else begin
               w_wcnt_n  = r_wcnt + 2'd1;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_state_n  = S_DATA;
               w_bitcnt_n = '0;
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_shift_n = {1'b0, r_shift[7:1]};
               if (r_bitcnt == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  w_state_n = S_PARITY;
`else
                  w_state_n = S_STOP;
`endif
               end else begin
                  w_bitcnt_n = r_bitcnt + 3'd1;
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_tick) w_state_n = S_STOP;
         end
`endif
         S_STOP: begin
            if (w_tick) w_state_n = S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered pins line up
   // with the state they describe; o_rd looks ahead so the pop lands in the
   // first IDLE cycle.
   always_comb begin
      w_rd_n   = (w_state_n == S_IDLE) && !i_empty;
      w_busy_n = (w_state_n != S_IDLE) || w_rd_n;
      case (w_state_n)
         S_START:  w_tx_n = 1'b0;
         S_DATA:   w_tx_n = w_shift_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: w_tx_n = w_par_n;
`endif
         default:  w_tx_n = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_wcnt   <= '0;
         r_rd     <= 1'b0;
         r_tx     <= TX_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         r_par    <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_n;
         r_shift  <= w_shift_n;
         r_bitcnt <= w_bitcnt_n;
         r_wcnt   <= w_wcnt_n;
         r_rd     <= w_rd_n;
         r_tx     <= w_tx_n;
         r_busy   <= w_busy_n;
         r_done   <= (r_state == S_STOP) && (w_cnt == DONE_CNT);
         r_err    <= w_err_n;
`ifdef FIFO_UART_TX_PARITY_EN
         r_par    <= w_par_n;
`endif
      end
   end

   assign o_rd        = r_rd;
   assign o_tx        = r_tx;
   assign o_busy      = r_busy;
   assign o_byte_done = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: 1-cycle-latency FIFO model, line trace and frame decoder.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FL = FB * CPB;
   localparam int NT = 8192;

   logic       clk = 1'b0, rst = 1'b1, empty = 1'b1, dr = 1'b0;
   logic [7:0] din = 8'h00;
   logic       rd, tx, busy, done, err;

   fifo_uart_tx #(.CLK_FREQ(4), .BAUD(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_empty(empty), .i_data_ready(dr), .i_din(din),
      .o_rd(rd), .o_tx(tx), .o_busy(busy), .o_byte_done(done), .o_err(err)
   );

   always #5 clk = ~clk;

   // FIFO model: data valid the cycle after a sampled read request
   logic [7:0] q[$];
   bit         supp = 1'b0;
   always @(posedge clk) begin
      logic [7:0] t;
      dr <= 1'b0;
      if (rd && q.size() > 0) begin
         t = q.pop_front();
         din <= t;
         dr  <= !supp;
      end
      empty <= (q.size() == 0);
   end

   bit tx_a[NT], rd_a[NT], dn_a[NT], by_a[NT];
   int n = 0, viol = 0;
   always @(negedge clk) begin
      if (n < NT) begin
         tx_a[n] = tx; rd_a[n] = rd; dn_a[n] = done; by_a[n] = busy;
      end
      if (rd && empty) viol++;
      n++;
   end

   int tests = 0, fails = 0;
   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) begin @(negedge clk); #1; end
   endtask

   function automatic bit fbit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return b[3'(j-1)];
      if (FB == 11 && j == 9) return ^b;
      return 1'b1;
   endfunction

   int fs[$], fv[$], fbad[$];
   logic [7:0] eq[$];

   task automatic scan(input int from, input int to, output int nrd, output int ndn);
      int i;
      logic [7:0] v;
      int bad;
      fs.delete(); fv.delete(); fbad.delete();
      nrd = 0; ndn = 0;
      for (int k = from; k < to; k++) begin nrd += int'(rd_a[k]); ndn += int'(dn_a[k]); end
      i = from;
      while (i + FL <= to) begin
         if (tx_a[i] == 1'b0 && (i == 0 || tx_a[i-1] == 1'b1)) begin
            for (int j = 1; j <= 8; j++) v[j-1] = tx_a[i + j*CPB + CPB/2];
            bad = 0;
            for (int j = 0; j < FB; j++)
               for (int k = 0; k < CPB; k++)
                  if (tx_a[i + j*CPB + k] != fbit(v, j)) bad++;
            fs.push_back(i); fv.push_back(int'(v)); fbad.push_back(bad);
            i += FL;
         end else i++;
      end
   endtask

   task automatic chk_frames(input string tag, input int from, input int to);
      int nrd, ndn;
      scan(from, to, nrd, ndn);
      chk({tag, "_nframes"}, fs.size(), eq.size());
      chk({tag, "_nrd"}, nrd, eq.size());
      chk({tag, "_ndone"}, ndn, eq.size());
      for (int k = 0; k < fs.size() && k < eq.size(); k++) begin
         chk($sformatf("%s_byte%0d", tag, k), fv[k], int'(eq[k]));
         chk($sformatf("%s_shape%0d", tag, k), fbad[k], 0);
         chk($sformatf("%s_done%0d", tag, k), int'(dn_a[fs[k] + FL - 1]), 1);
      end
   endtask

   task automatic wait_rd(input string tag, output int c);
      c = -1;
      for (int t = 0; t < 100 && c < 0; t++) begin
         step(1);
         if (rd) c = n - 1;
      end
      chk({tag, "_rd_seen"}, int'(c >= 0), 1);
      if (c < 0) c = n - 1;
   endtask

   function automatic int first_done(input int from, input int to);
      for (int k = from; k < to; k++) if (dn_a[k]) return k;
      return -1;
   endfunction

   initial begin
      #70000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   initial begin
      int base, c, d, lows, bsy, nrd;
      // reset state
      step(3);
      chk("rst_tx", tx, 1); chk("rst_rd", rd, 0); chk("rst_busy", busy, 0);
      chk("rst_done", done, 0); chk("rst_err", err, 0);
      rst = 1'b0;
      base = n;
      step(50);
      lows = 0; bsy = 0; nrd = 0;
      for (int k = base; k < n; k++) begin
         lows += int'(!tx_a[k]); bsy += int'(by_a[k]); nrd += int'(rd_a[k]);
      end
      chk("idle_tx_low", lows, 0); chk("idle_busy", bsy, 0);
      chk("idle_rd", nrd, 0); chk("idle_err", err, 0);

      // single byte 0xA5
      q.push_back(8'hA5); eq = '{8'hA5};
      wait_rd("a5", c);
      step(FL + 8);
      chk_frames("a5", c, n);
      d = first_done(c, n);
      chk("a5_latency", d - c, FL + 1);
      if (fs.size() > 0) chk("a5_start", fs[0] - c, 2);
      bsy = 0;
      for (int k = c; k <= d && k >= 0; k++) bsy += int'(by_a[k]);
      chk("a5_busy_span", bsy, d - c + 1);
      if (d >= 0) chk("a5_busy_after", int'(by_a[d+1]), 0);

      // back-to-back
      eq = '{8'h00, 8'hFF, 8'h3C};
      foreach (eq[k]) q.push_back(eq[k]);
      wait_rd("b2b", c);
      step(3 * (FL + 3) + 10);
      chk_frames("b2b", c, n);
      for (int k = 1; k < fs.size(); k++)
         chk($sformatf("b2b_gap%0d", k), fs[k] - (fs[k-1] + FL), 2);
      chk("b2b_empty", empty, 1);
      chk("b2b_qsize", q.size(), 0);

      // data never returned
      supp = 1'b1;
      q.push_back(8'h55);
      wait_rd("err", c);
      step(2);
      chk("err_early", err, 0);
      step(1);
      chk("err_set", err, 1);
      chk("err_busy", busy, 0);
      step(8);
      lows = 0; nrd = 0;
      for (int k = c; k < n; k++) lows += int'(!tx_a[k]);
      for (int k = c + 1; k < n; k++) nrd += int'(rd_a[k]);
      chk("err_tx_low", lows, 0);
      chk("err_no_rd", nrd, 0);
      chk("err_sticky", err, 1);
      supp = 1'b0;

      // reset during data bit 3
      rst = 1'b1; step(2); rst = 1'b0; step(2);
      chk("rst2_err", err, 0);
      q.push_back(8'h5A); q.push_back(8'hC3);
      wait_rd("mid", c);
      step(2 + 4*CPB + 1);
      chk("mid_pre_tx", tx, 1);
      chk("mid_pre_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rd", rd, 0);
      step(2);
      rst = 1'b0;
      base = n;
      eq = '{8'hC3};
      step(FL + 12);
      chk_frames("after_rst", base, n);

      // 0x07: parity bit is 1 when enabled
      eq = '{8'h07};
      q.push_back(8'h07);
      wait_rd("p07", c);
      step(FL + 8);
      chk_frames("p07", c, n);
      d = first_done(c, n);
      chk("p07_len", d - c, FL + 1);
`ifdef FIFO_UART_TX_PARITY_EN
      if (fs.size() > 0) chk("p07_par", int'(tx_a[fs[0] + 9*CPB + 1]), 1);
`endif

      // random bytes at random times
      eq.delete();
      base = n;
      for (int k = 0; k < 6; k++) begin
         logic [7:0] b;
         b = 8'($urandom);
         q.push_back(b); eq.push_back(b);
         step($urandom_range(0, FL + 10));
      end
      step(6 * (FL + 4) + 10);
      chk_frames("rnd", base, n);

      chk("rd_while_empty", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
